// File: rtl/green_pkg.sv
// Shared encodings for the Green core control path: op codes and flag positions.
package green_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_BR   = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  // Flag positions counted from the MSB of the flag vector: {Z,N,C} or {Z,N,C,V}
  typedef enum int unsigned {
    FLAG_Z = 0,
    FLAG_N = 1,
    FLAG_C = 2,
    FLAG_V = 3
  } flag_pos_e;

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is refused and flagged; sticky errors clear on i_err_clr.
module branch_ras
  import green_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_hold,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_err_clr,
  input  logic [ADDR_W-1:0]              i_push_addr,
  output logic [ADDR_W-1:0]              o_top_c,
  output logic [$clog2(RAS_DEPTH):0]     o_cnt,
  output logic                           o_ovf,
  output logic                           o_unf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_unf;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [PTR_W-1:0]  w_top_idx;

  assign w_full    = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_push    = !i_hold && i_push;
  assign w_pop     = !i_hold && i_pop && !w_empty;
  assign w_ovf_set = w_push && w_full;
  assign w_unf_set = !i_hold && i_pop && w_empty;
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_top_c   = r_mem[w_top_idx];

  // r_ptr names the next free slot; once full it also names the oldest entry
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_ptr] <= i_push_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push) begin
        r_ptr <= r_ptr + PTR_W'(1);
        if (!w_full) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_pop) begin
        r_ptr <= w_top_idx;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // a set event in the same cycle as a clear wins
      if (!i_hold) begin
        r_ovf <= w_ovf_set || (r_ovf && !i_err_clr);
        r_unf <= w_unf_set || (r_unf && !i_err_clr);
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
  assign o_unf = r_unf;

endmodule

// File: rtl/branch_unit.sv
// Branch/PC sequencing unit: flag register, masked branch conditions,
// PC-relative targets, conditional CALL/RET via the return-address stack.
module branch_unit
  import green_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 16,
  parameter int unsigned          OFF_W     = 8,
  parameter int unsigned          NFLAGS    = 3,
  parameter int unsigned          RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        op_valid,
  input  logic [1:0]                  op,
  input  logic                        inv,
  input  logic [NFLAGS-1:0]           mask,
  input  logic [OFF_W-1:0]            offset,
  input  logic                        flag_we,
  input  logic [NFLAGS-1:0]           flag_d,
  input  logic                        err_clr,
  output logic [ADDR_W-1:0]           pc_o,
  output logic                        taken_o,
  output logic                        flush_o,
  output logic [NFLAGS-1:0]           flags_o,
  output logic [$clog2(RAS_DEPTH):0]  ras_cnt_o,
  output logic                        ras_ovf_o,
  output logic                        ras_unf_o
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc;
  logic              r_taken;
  logic              r_flush;
  logic [NFLAGS-1:0] r_flags;

  logic [NFLAGS-1:0] w_flags_eff;
  logic              w_cond;
  logic [ADDR_W-1:0] w_off_sext;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_redirect;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_ras_top;
  logic [CNT_W-1:0]  w_ras_cnt;
  logic              w_ras_ovf;
  logic              w_ras_unf;

  // same-cycle flag writes are visible to the branch being evaluated
  assign w_flags_eff = flag_we ? flag_d : r_flags;

  // empty mask means always (inv=0); full mask means always (inv=1)
  assign w_cond = inv ? ((|(mask & ~w_flags_eff)) || (&mask))
                      : ((|(mask & w_flags_eff))  || !(|mask));

  assign w_off_sext = ADDR_W'($signed(offset));
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_target   = r_pc + w_off_sext;

  always_comb begin
    w_pc_nxt   = w_pc_inc;
    w_redirect = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    if (op_valid) begin
      case (op_e'(op))
        OP_BR: begin
          if (w_cond) begin
            w_pc_nxt   = w_target;
            w_redirect = 1'b1;
          end
        end
        OP_CALL: begin
          if (w_cond) begin
            w_push     = 1'b1;
            w_pc_nxt   = w_target;
            w_redirect = 1'b1;
          end
        end
        OP_RET: begin
          // an empty-stack pop is flagged inside the RAS and falls through to pc+1
          if (w_cond) begin
            w_pop = 1'b1;
            if (w_ras_cnt != '0) begin
              w_pc_nxt   = w_ras_top;
              w_redirect = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  branch_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .i_hold      (stall),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_err_clr   (err_clr),
    .i_push_addr (w_pc_inc),
    .o_top_c     (w_ras_top),
    .o_cnt       (w_ras_cnt),
    .o_ovf       (w_ras_ovf),
    .o_unf       (w_ras_unf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
    end else if (flag_we) begin
      r_flags <= flag_d;
    end
  end

  // flush only follows an accepted redirect; a stall drops it rather than extending it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
      r_flush <= 1'b0;
    end else if (!stall) begin
      r_pc    <= w_pc_nxt;
      r_taken <= w_redirect;
      r_flush <= w_redirect;
    end else begin
      r_flush <= 1'b0;
    end
  end

  assign pc_o      = r_pc;
  assign taken_o   = r_taken;
  assign flush_o   = r_flush;
  assign flags_o   = r_flags;
  assign ras_cnt_o = w_ras_cnt;
  assign ras_ovf_o = w_ras_ovf;
  assign ras_unf_o = w_ras_unf;

endmodule

// File: tb/tb_branch_unit.sv
// Directed and random checks of branch_unit against a queue-based reference model.
module tb_branch_unit;
  import green_pkg::*;

  localparam int RAS_D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        inv = 1'b0;
  logic [2:0]  mask = 3'd0;
  logic [7:0]  offset = 8'd0;
  logic        flag_we = 1'b0;
  logic [2:0]  flag_d = 3'd0;
  logic        err_clr = 1'b0;
  logic [15:0] pc_o;
  logic        taken_o;
  logic        flush_o;
  logic [2:0]  flags_o;
  logic [2:0]  ras_cnt_o;
  logic        ras_ovf_o;
  logic        ras_unf_o;

  branch_unit #(
    .ADDR_W(16), .OFF_W(8), .NFLAGS(3), .RAS_DEPTH(RAS_D), .RESET_PC(16'd0)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .op_valid(op_valid), .op(op),
    .inv(inv), .mask(mask), .offset(offset), .flag_we(flag_we), .flag_d(flag_d),
    .err_clr(err_clr), .pc_o(pc_o), .taken_o(taken_o), .flush_o(flush_o),
    .flags_o(flags_o), .ras_cnt_o(ras_cnt_o), .ras_ovf_o(ras_ovf_o),
    .ras_unf_o(ras_unf_o)
  );

  always #5 clk = ~clk;

  int       total = 0;
  int       bad = 0;
  int       mpc;
  bit [2:0] mflags;
  bit       mtaken, mflush, movf, munf;
  int       ras_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpc = 0; mflags = 3'd0; mtaken = 1'b0; mflush = 1'b0;
    movf = 1'b0; munf = 1'b0; ras_q.delete();
  endtask

  task automatic check_all();
    chk("pc", 32'(pc_o), 32'(mpc));
    chk("taken", 32'(taken_o), 32'(mtaken));
    chk("flush", 32'(flush_o), 32'(mflush));
    chk("flags", 32'(flags_o), 32'(mflags));
    chk("ras_cnt", 32'(ras_cnt_o), 32'(ras_q.size()));
    chk("ras_ovf", 32'(ras_ovf_o), 32'(movf));
    chk("ras_unf", 32'(ras_unf_o), 32'(munf));
  endtask

  // One clock of architectural behaviour, computed from the current inputs
  task automatic model_step();
    bit [2:0] f;
    bit       cond, redirect, so, su;
    int       off, npc;
    f   = flag_we ? flag_d : mflags;
    off = int'($signed(offset));
    if (inv) cond = ((mask & ~f) != 3'd0) || (mask == 3'b111);
    else     cond = ((mask & f) != 3'd0) || (mask == 3'b000);
    redirect = 1'b0; so = 1'b0; su = 1'b0;
    npc = (mpc + 1) & 16'hFFFF;
    if (!stall && op_valid) begin
      if (op == OP_BR && cond) begin
        npc = (mpc + off) & 16'hFFFF; redirect = 1'b1;
      end else if (op == OP_CALL && cond) begin
        ras_q.push_back((mpc + 1) & 16'hFFFF);
        if (ras_q.size() > RAS_D) begin
          void'(ras_q.pop_front());
          so = 1'b1;
        end
        npc = (mpc + off) & 16'hFFFF; redirect = 1'b1;
      end else if (op == OP_RET && cond) begin
        if (ras_q.size() > 0) begin
          npc = ras_q.pop_back(); redirect = 1'b1;
        end else begin
          su = 1'b1;
        end
      end
    end
    if (flag_we) mflags = flag_d;
    if (!stall) begin
      mpc = npc; mtaken = redirect; mflush = redirect;
      movf = so || (movf && !err_clr);
      munf = su || (munf && !err_clr);
    end else begin
      mflush = 1'b0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_op(input bit v, input logic [1:0] o, input bit i,
                        input logic [2:0] m, input logic [7:0] off);
    op_valid = v; op = o; inv = i; mask = m; offset = off;
  endtask

  task automatic idle_to(input int target);
    set_op(1'b0, OP_NOP, 1'b0, 3'd0, 8'd0);
    for (int k = 0; k < 64 && mpc != target; k++) step();
    chk("reach_pc", 32'(pc_o), 32'(target));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // free-running increments
    repeat (3) step();
    chk("count3", 32'(pc_o), 32'd3);

    // flag write during stall, then BR taken backwards from pc=10
    idle_to(10);
    stall = 1'b1; flag_we = 1'b1; flag_d = 3'b100;
    step();
    stall = 1'b0; flag_we = 1'b0;
    set_op(1'b1, OP_BR, 1'b0, 3'b100, 8'hFC);
    step();
    chk("br_taken_pc", 32'(pc_o), 32'd6);
    chk("br_flush", 32'(flush_o), 32'd1);
    set_op(1'b0, OP_NOP, 1'b0, 3'd0, 8'd0);
    step();
    chk("flush_one_cycle", 32'(flush_o), 32'd0);

    // inverted condition not taken
    idle_to(10);
    set_op(1'b1, OP_BR, 1'b1, 3'b100, 8'hFC);
    step();
    chk("br_inv_pc", 32'(pc_o), 32'd11);

    // forwarded C flag
    flag_we = 1'b1; flag_d = 3'b001;
    set_op(1'b1, OP_BR, 1'b0, 3'b001, 8'd5);
    step();
    flag_we = 1'b0;
    chk("fwd_taken", 32'(taken_o), 32'd1);
    chk("fwd_pc", 32'(pc_o), 32'd16);

    // held BR under stall, then release; stall right after redirect drops flush
    set_op(1'b1, OP_BR, 1'b0, 3'b000, 8'd20);
    stall = 1'b1;
    repeat (3) step();
    chk("stall_pc", 32'(pc_o), 32'd16);
    stall = 1'b0;
    step();
    chk("stall_release_pc", 32'(pc_o), 32'd36);
    set_op(1'b0, OP_NOP, 1'b0, 3'd0, 8'd0);
    stall = 1'b1;
    step();
    stall = 1'b0;
    step();

    // five CALLs overflow a 4-deep stack, then unwind and underflow
    set_op(1'b1, OP_CALL, 1'b0, 3'd0, 8'd3);
    repeat (5) step();
    chk("call_cnt", 32'(ras_cnt_o), 32'd4);
    chk("call_ovf", 32'(ras_ovf_o), 32'd1);
    set_op(1'b1, OP_RET, 1'b0, 3'd0, 8'd0);
    repeat (4) step();
    set_op(1'b1, OP_RET, 1'b0, 3'd0, 8'd0);
    step();
    chk("ret_unf", 32'(ras_unf_o), 32'd1);
    chk("ret_unf_noflush", 32'(flush_o), 32'd0);

    // error clear, then clear colliding with a new underflow
    set_op(1'b0, OP_NOP, 1'b0, 3'd0, 8'd0);
    err_clr = 1'b1;
    step();
    set_op(1'b1, OP_RET, 1'b0, 3'd0, 8'd0);
    step();
    chk("set_wins", 32'(ras_unf_o), 32'd1);
    set_op(1'b0, OP_NOP, 1'b0, 3'd0, 8'd0);
    step();
    err_clr = 1'b0;

    // asynchronous reset with two entries on the stack
    set_op(1'b1, OP_CALL, 1'b0, 3'd0, 8'd7);
    repeat (2) step();
    chk("pre_rst_cnt", 32'(ras_cnt_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    set_op(1'b1, OP_RET, 1'b0, 3'd0, 8'd0);
    step();
    chk("post_rst_unf", 32'(ras_unf_o), 32'd1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      stall    = ($urandom_range(0, 4) == 0);
      op_valid = ($urandom_range(0, 9) < 7);
      op       = 2'($urandom_range(0, 3));
      inv      = 1'($urandom_range(0, 1));
      mask     = 3'($urandom_range(0, 7));
      offset   = 8'($urandom_range(0, 255));
      flag_we  = ($urandom_range(0, 9) < 3);
      flag_d   = 3'($urandom_range(0, 7));
      err_clr  = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
